prog_mod_counter: RTL and testbench
===================================

PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter/divisor bit width.
REQ-002 SHALL have parameter DEFAULT_DIV, default 10, divisor loaded at reset.
REQ-003 SHALL have port CLK  input  1  single clock; all logic updates on falling edge.
REQ-004 SHALL have port CLEAR  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port START  input  1  start/restart a count sequence.
REQ-006 SHALL have port EN  input  1  count-event enable; one event per enabled edge.
REQ-007 SHALL have port DIR_DOWN  input  1  direction, sampled at START; 1 = down.
REQ-008 SHALL have port ONESHOT  input  1  mode, sampled at START; 1 = single sequence, 0 = continuous.
REQ-009 SHALL have port DIV_IN  input  WIDTH  new divisor N.
REQ-010 SHALL have port DIV_VALID  input  1  DIV_IN valid.
REQ-011 SHALL have port DIV_READY  output  1  shadow slot free.
REQ-012 SHALL have port Count  output  WIDTH  current count state.
REQ-013 SHALL have port OUT  output  1  terminal-event pulse, one per N events.
REQ-014 SHALL have port BUSY  output  1  high while state RUN.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse on one-shot completion.

Function
REQ-016 SHALL implement states IDLE and RUN; IDLE->RUN on START; RUN->IDLE on one-shot completion; START in RUN restarts the sequence.
REQ-017 SHALL load Count with the start value on START: 0 for up, DIV-1 for down.
REQ-018 SHALL hold Count and drive OUT=0 in any cycle with EN=0 or state IDLE.
REQ-019 SHALL, in RUN with EN=1, step Count by one toward the terminal value: DIV-1 for up, 0 for down.
REQ-020 SHALL register OUT=1 on the same edge Count becomes the terminal value, and OUT=0 on every other edge.
REQ-021 SHALL, in continuous mode, advance Count from the terminal value to the start value on the next enabled edge.
REQ-022 SHALL, in one-shot mode, go to IDLE on the enabled edge after the terminal value, reload Count with the start value and pulse DONE for one cycle.
REQ-023 SHALL hold one shadow divisor: accept on DIV_VALID & DIV_READY; DIV_READY=0 while the shadow is occupied.
REQ-024 SHALL apply the shadow divisor immediately in IDLE, on START, or at the wrap edge in RUN (terminal -> start), then free the slot.
REQ-025 SHALL NOT apply a divisor accepted on the wrap edge at that wrap; it applies at the next wrap.
REQ-026 SHALL clamp accepted divisor values 0 and 1 to 2.
REQ-027 SHALL perform all count arithmetic modulo 2^WIDTH, with no carry outside WIDTH bits; DIV=2^WIDTH-1 is the maximum.
REQ-028 SHALL give START priority over EN-driven stepping on the same edge.

Reset
REQ-029 SHALL, on CLEAR=1 at a falling CLK edge, set the state to IDLE, Count=0, OUT=0, DONE=0, BUSY=0, DIV=DEFAULT_DIV, shadow empty (DIV_READY=1), direction up and mode continuous.
REQ-030 SHALL give CLEAR priority over START, EN and DIV_VALID, including mid-sequence.

Structure
REQ-031 SHALL place the state encoding (IDLE, RUN) and the minimum divisor constant 2 in the shared package.
REQ-032 SHALL implement the divisor handshake plus shadow register as sub-module div_shadow_reg; the counter FSM stays in prog_mod_counter.

Verification
REQ-033 SHALL verify default up-count: CLEAR, START, 25 EN edges -> Count 0..9 repeating; OUT high at Count=9 only, 2 pulses in 20 events.
REQ-034 SHALL verify down one-shot: DIV_IN=5 in IDLE, START with DIR_DOWN=1 and ONESHOT=1, EN held -> Count 4,3,2,1,0; OUT at 0; next edge gives DONE pulse, BUSY=0, Count=4.
REQ-035 SHALL verify the shadow update: running DIV=10, write 6 at Count=3 -> DIV_READY drops; sequence finishes to 9, then counts 0..5; DIV_READY returns after the wrap.
REQ-036 SHALL verify the wrap collision: DIV_VALID=1 with 4 on the 9->0 edge -> the following sequence still uses 10, and the one after uses 4.
REQ-037 SHALL verify clamp and gaps: DIV_IN=1 -> period 2; EN toggled every other cycle -> Count holds, OUT=0 on idle cycles.
REQ-038 SHALL verify reset mid-run: CLEAR at Count=7 with a pending shadow -> the next edge gives Count=0, IDLE, DIV=10, DIV_READY=1.

Source files
------------

// File: rtl/prog_mod_counter_pkg.sv
// Shared definitions for the programmable modulo counter.
// Holds the FSM state encoding and the smallest legal divisor.
// Ports: none (package only).
package prog_mod_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Divisor values below this are raised to it on acceptance, so every
  // sequence has distinct start and terminal values.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/div_shadow_reg.sv
// One-entry shadow register for a new divisor, with a valid/ready handshake.
// Ports: clk (falling-edge), clear (sync reset), div_in/div_valid/div_ready (write side),
//        consume (counter took the value), full/div_val (pending divisor, already clamped).
module div_shadow_reg
  import prog_mod_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             consume,
  output logic             full,
  output logic [WIDTH-1:0] div_val
);

  logic             full_q;
  logic [WIDTH-1:0] val_q;
  logic             accept;

  // A slot is only accepted into while empty and only consumed while full,
  // so accept and consume never coincide.
  assign accept    = div_valid & ~full_q;
  assign div_ready = ~full_q;
  assign full      = full_q;
  assign div_val   = val_q;

  always_ff @(negedge clk) begin
    if (clear) begin
      full_q <= 1'b0;
      val_q  <= '0;
    end else if (consume) begin
      full_q <= 1'b0;
    end else if (accept) begin
      full_q <= 1'b1;
      val_q  <= (div_in < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_in;
    end
  end

endmodule

// File: rtl/prog_mod_counter.sv
// Programmable modulo-N up/down counter with one-shot or continuous mode.
// Ports: CLK (falling-edge), CLEAR (sync reset), START/EN/DIR_DOWN/ONESHOT (control),
//        DIV_IN/DIV_VALID/DIV_READY (divisor update), Count/OUT/BUSY/DONE (status).
module prog_mod_counter
  import prog_mod_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             CLK,
  input  logic             CLEAR,
  input  logic             START,
  input  logic             EN,
  input  logic             DIR_DOWN,
  input  logic             ONESHOT,
  input  logic [WIDTH-1:0] DIV_IN,
  input  logic             DIV_VALID,
  output logic             DIV_READY,
  output logic [WIDTH-1:0] Count,
  output logic             OUT,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;

  logic             consume;
  logic             shadow_full;
  logic [WIDTH-1:0] shadow_div;
  logic [WIDTH-1:0] div_apply;
  logic [WIDTH-1:0] step;
  logic             at_term;

  div_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
    .clk       (CLK),
    .clear     (CLEAR),
    .div_in    (DIV_IN),
    .div_valid (DIV_VALID),
    .div_ready (DIV_READY),
    .consume   (consume),
    .full      (shadow_full),
    .div_val   (shadow_div)
  );

  // Divisor in force after an edge where a pending shadow may be taken.
  assign div_apply = shadow_full ? shadow_div : div_q;
  assign at_term   = dir_q ? (count_q == '0) : (count_q == div_q - WIDTH'(1));
  assign step      = dir_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    out_d   = 1'b0;
    done_d  = 1'b0;
    dir_d   = dir_q;
    mode_d  = mode_q;
    consume = 1'b0;

    if (START) begin
      // START wins over stepping and (re)loads the sequence with fresh mode bits.
      state_d = RUN;
      dir_d   = DIR_DOWN;
      mode_d  = ONESHOT;
      div_d   = div_apply;
      consume = shadow_full;
      count_d = DIR_DOWN ? (div_apply - WIDTH'(1)) : '0;
    end else if (state_q == IDLE) begin
      div_d   = div_apply;
      consume = shadow_full;
    end else if (EN) begin
      if (at_term) begin
        // Wrap edge: the only point in RUN where a pending divisor takes effect.
        div_d   = div_apply;
        consume = shadow_full;
        count_d = dir_q ? (div_apply - WIDTH'(1)) : '0;
        if (mode_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        count_d = step;
        out_d   = dir_q ? (step == '0) : (step == div_q - WIDTH'(1));
      end
    end

    if (CLEAR) begin
      consume = 1'b0;
    end
  end

  always_ff @(negedge CLK) begin
    if (CLEAR) begin
      state_q <= IDLE;
      count_q <= '0;
      div_q   <= WIDTH'(DEFAULT_DIV);
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      out_q   <= out_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign Count = count_q;
  assign OUT   = out_q;
  assign DONE  = done_q;
  assign BUSY  = (state_q == RUN);

endmodule

// File: tb/tb_prog_mod_counter.sv
// Scoreboard bench for prog_mod_counter: stimulus pushes hand-computed
// expectations, a monitor pops and compares after every falling edge.
// Ports: none (top-level bench).
module tb_prog_mod_counter;

  typedef struct packed {
    logic [3:0] count;
    logic       out;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic       en = 1'b0;
  logic       dir_down = 1'b0;
  logic       oneshot = 1'b0;
  logic [3:0] div_in = 4'd0;
  logic       div_valid = 1'b0;
  logic       div_ready;
  logic [3:0] count;
  logic       out_p;
  logic       busy;
  logic       done;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  prog_mod_counter #(.WIDTH(4), .DEFAULT_DIV(10)) dut (
    .CLK       (clk),
    .CLEAR     (clear),
    .START     (start),
    .EN        (en),
    .DIR_DOWN  (dir_down),
    .ONESHOT   (oneshot),
    .DIV_IN    (div_in),
    .DIV_VALID (div_valid),
    .DIV_READY (div_ready),
    .Count     (count),
    .OUT       (out_p),
    .BUSY      (busy),
    .DONE      (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t E(input int c, input bit o, input bit b, input bit d, input bit r);
    exp_t e;
    e.count = c[3:0];
    e.out   = o;
    e.busy  = b;
    e.done  = d;
    e.ready = r;
    return e;
  endfunction

  // Inputs are set just after a rising edge; the DUT samples them on the
  // following falling edge, whose result the monitor checks.
  task automatic tick(input exp_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic do_reset();
    clear = 1'b1; start = 1'b0; en = 1'b0; div_valid = 1'b0;
    dir_down = 1'b0; oneshot = 1'b0;
    tick(E(0, 0, 0, 0, 1), "reset");
    clear = 1'b0;
  endtask

  // Monitor: compares the DUT state after each falling edge with the oldest expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_tests++;
        if (count !== e.count || out_p !== e.out || busy !== e.busy ||
            done !== e.done || div_ready !== e.ready) begin
          n_fail++;
          $display("FAIL %s: got count=%0d out=%b busy=%b done=%b ready=%b, want count=%0d out=%b busy=%b done=%b ready=%b",
                   nm, count, out_p, busy, done, div_ready,
                   e.count, e.out, e.busy, e.done, e.ready);
        end
      end
    end
  end

  initial begin
    @(posedge clk);

    // Default up-count, 25 enabled edges with DIV=10; then restart mid-run.
    do_reset();
    start = 1'b1; en = 1'b0;
    tick(E(0, 0, 1, 0, 1), "up_start");
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 25; i++)
      tick(E(i % 10, (i % 10) == 9, 1, 0, 1), "up_count");
    start = 1'b1;
    tick(E(0, 0, 1, 0, 1), "restart_priority");
    start = 1'b0;

    // Down one-shot with DIV=5 loaded in IDLE.
    do_reset();
    div_in = 4'd5; div_valid = 1'b1;
    tick(E(0, 0, 0, 0, 0), "idle_accept");
    div_valid = 1'b0;
    tick(E(0, 0, 0, 0, 1), "idle_apply");
    start = 1'b1; dir_down = 1'b1; oneshot = 1'b1; en = 1'b1;
    tick(E(4, 0, 1, 0, 1), "down_start");
    start = 1'b0;
    tick(E(3, 0, 1, 0, 1), "down_3");
    tick(E(2, 0, 1, 0, 1), "down_2");
    tick(E(1, 0, 1, 0, 1), "down_1");
    tick(E(0, 1, 1, 0, 1), "down_term");
    tick(E(4, 0, 0, 1, 1), "oneshot_done");
    tick(E(4, 0, 0, 0, 1), "done_one_cycle");

    // Shadow update mid-sequence: 6 written at Count=3.
    do_reset();
    start = 1'b1;
    tick(E(0, 0, 1, 0, 1), "shadow_start");
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 3; i++) tick(E(i, 0, 1, 0, 1), "shadow_pre");
    div_in = 4'd6; div_valid = 1'b1;
    tick(E(4, 0, 1, 0, 0), "shadow_accept");
    div_valid = 1'b0;
    for (int i = 5; i <= 9; i++) tick(E(i, i == 9, 1, 0, 0), "shadow_old_div");
    tick(E(0, 0, 1, 0, 1), "shadow_wrap");
    for (int i = 1; i <= 5; i++) tick(E(i, i == 5, 1, 0, 1), "shadow_new_div");
    tick(E(0, 0, 1, 0, 1), "shadow_wrap2");

    // Divisor offered on the 9->0 wrap edge applies one wrap later.
    do_reset();
    start = 1'b1;
    tick(E(0, 0, 1, 0, 1), "coll_start");
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 9; i++) tick(E(i, i == 9, 1, 0, 1), "coll_first");
    div_in = 4'd4; div_valid = 1'b1;
    tick(E(0, 0, 1, 0, 0), "coll_wrap_accept");
    div_valid = 1'b0;
    for (int i = 1; i <= 9; i++) tick(E(i, i == 9, 1, 0, 0), "coll_still_10");
    tick(E(0, 0, 1, 0, 1), "coll_wrap_apply");
    for (int i = 1; i <= 3; i++) tick(E(i, i == 3, 1, 0, 1), "coll_div4");
    tick(E(0, 0, 1, 0, 1), "coll_div4_wrap");

    // Clamp of DIV_IN=1 to 2, with EN gaps.
    do_reset();
    div_in = 4'd1; div_valid = 1'b1;
    tick(E(0, 0, 0, 0, 0), "clamp_accept");
    div_valid = 1'b0;
    tick(E(0, 0, 0, 0, 1), "clamp_apply");
    start = 1'b1;
    tick(E(0, 0, 1, 0, 1), "clamp_start");
    start = 1'b0;
    en = 1'b1; tick(E(1, 1, 1, 0, 1), "clamp_term");
    en = 1'b0; tick(E(1, 0, 1, 0, 1), "gap_hold");
    en = 1'b1; tick(E(0, 0, 1, 0, 1), "clamp_wrap");
    en = 1'b0; tick(E(0, 0, 1, 0, 1), "gap_hold2");
    en = 1'b1; tick(E(1, 1, 1, 0, 1), "clamp_term2");
    en = 1'b0; tick(E(1, 0, 1, 0, 1), "gap_hold3");

    // CLEAR at Count=7 with a pending shadow, asserted alongside START/EN/DIV_VALID.
    do_reset();
    start = 1'b1;
    tick(E(0, 0, 1, 0, 1), "clr_start");
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 6; i++) tick(E(i, 0, 1, 0, 1), "clr_pre");
    div_in = 4'd3; div_valid = 1'b1;
    tick(E(7, 0, 1, 0, 0), "clr_pending");
    clear = 1'b1; start = 1'b1; div_in = 4'd5;
    tick(E(0, 0, 0, 0, 1), "clr_mid_run");
    clear = 1'b0; start = 1'b0; en = 1'b0; div_valid = 1'b0;
    tick(E(0, 0, 0, 0, 1), "clr_idle");
    start = 1'b1;
    tick(E(0, 0, 1, 0, 1), "clr_restart");
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 9; i++) tick(E(i, i == 9, 1, 0, 1), "clr_div10");
    tick(E(0, 0, 1, 0, 1), "clr_div10_wrap");
    en = 1'b0;

    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
